// File: rtl/nice_traffic_pkg.sv
// Shared types and constants for the traffic reassembly chain.
package nice_traffic_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PEND    = 2'd1,
        DISCARD = 2'd2
    } asm_state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/nice_traffic_out_reg.sv
// Valid/ready holding register for one completed frame; a load wins over a consume.
module nice_traffic_out_reg #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [MAX_BEATS*DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]            load_len,
    input  logic                        load_trunc,
    input  logic                        up_ready,
    output logic                        up_valid,
    output logic [MAX_BEATS*DATA_W-1:0] up_data,
    output logic [LEN_W-1:0]            up_len,
    output logic                        up_trunc,
    output logic                        out_free
);

    assign out_free = !up_valid || up_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_valid <= 1'b0;
            up_data  <= '0;
            up_len   <= '0;
            up_trunc <= 1'b0;
        end else if (load) begin
            up_valid <= 1'b1;
            up_data  <= load_data;
            up_len   <= load_len;
            up_trunc <= load_trunc;
        end else if (up_ready) begin
            up_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nice_traffic_assembler.sv
// Reassembles last-terminated downstream beat bursts into one upper-level frame each.
module nice_traffic_assembler
    import nice_traffic_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        down_valid,
    output logic                        down_ready,
    input  logic [DATA_W-1:0]           down_data,
    input  logic                        down_last,
    output logic                        up_valid,
    input  logic                        up_ready,
    output logic [MAX_BEATS*DATA_W-1:0] up_data,
    output logic [LEN_W-1:0]            up_len,
    output logic                        up_trunc,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    asm_state_e                  state, state_next;
    logic [MAX_BEATS*DATA_W-1:0] col_data, col_data_next, ins_data;
    logic [LEN_W-1:0]            col_cnt, col_cnt_next;
    logic                        pend_trunc, pend_next;
    logic [DROP_CNT_W-1:0]       drop_next;
    logic                        load, load_trunc, out_free, at_full;
    logic [MAX_BEATS*DATA_W-1:0] load_data;
    logic [LEN_W-1:0]            load_len;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    // Ready depends only on registered state, never on up_ready.
    assign down_ready = (state != PEND);
    assign at_full    = (col_cnt == LEN_W'(MAX_BEATS - 1));

    always_comb begin
        ins_data = col_data;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (LEN_W'(i) == col_cnt) ins_data[i*DATA_W +: DATA_W] = down_data;
        end
    end

    always_comb begin
        state_next    = state;
        col_data_next = col_data;
        col_cnt_next  = col_cnt;
        pend_next     = pend_trunc;
        drop_next     = drop_cnt;
        load          = 1'b0;
        load_data     = col_data;
        load_len      = col_cnt;
        load_trunc    = pend_trunc;
        case (state)
            COLLECT: begin
                if (down_valid) begin
                    if (down_last || at_full) begin
                        if (out_free) begin
                            load          = 1'b1;
                            load_data     = ins_data;
                            load_len      = col_cnt + LEN_W'(1);
                            load_trunc    = !down_last;
                            col_data_next = '0;
                            col_cnt_next  = '0;
                            state_next    = down_last ? COLLECT : DISCARD;
                        end else begin
                            col_data_next = ins_data;
                            col_cnt_next  = col_cnt + LEN_W'(1);
                            pend_next     = !down_last;
                            state_next    = PEND;
                        end
                    end else begin
                        col_data_next = ins_data;
                        col_cnt_next  = col_cnt + LEN_W'(1);
                    end
                end
            end
            PEND: begin
                if (out_free) begin
                    load          = 1'b1;
                    col_data_next = '0;
                    col_cnt_next  = '0;
                    state_next    = pend_trunc ? DISCARD : COLLECT;
                end
            end
            DISCARD: begin
                if (down_valid) begin
                    drop_next = sat_inc(drop_cnt);
                    if (down_last) state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_data   <= '0;
            col_cnt    <= '0;
            pend_trunc <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            col_data   <= col_data_next;
            col_cnt    <= col_cnt_next;
            pend_trunc <= pend_next;
            drop_cnt   <= drop_next;
        end
    end

    nice_traffic_out_reg #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .LEN_W     (LEN_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_trunc (load_trunc),
        .up_ready   (up_ready),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_len     (up_len),
        .up_trunc   (up_trunc),
        .out_free   (out_free)
    );

endmodule
